// File: rtl/_shifter_reg_p_if.sv
`default_nettype none
// ============================================================================
// Module      : _shifter_reg_p_if
// Description : Command/result bundle for the _shifter_reg_p shift/rotate stage.
// Revision    : 1.0  initial release
// ============================================================================
interface _shifter_reg_p_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             clr;
    logic             start;
    logic [2:0]       op;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    modport master (
        output clr, start, op, amt, d_in,
        input  q, busy, done
    );

    modport slave (
        input  clr, start, op, amt, d_in,
        output q, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/_shifter_reg_p.sv
`default_nettype none
// ============================================================================
// Module      : _shifter_reg_p
// Description : WIDTH-bit load/shift/rotate register with start/busy/done
//               handshake. Iterative (one position per clock) by default;
//               define SHIFTER_BARREL_EN for single-edge barrel operation.
// Revision    : 1.0  initial release
// ============================================================================
module _shifter_reg_p #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  wire logic         clk,
    input  wire logic         reset,
    _shifter_reg_p_if.slave   bus
);

    localparam logic [2:0] c_OP_LOAD = 3'b001;
    localparam logic [2:0] c_OP_LSL  = 3'b010;
    localparam logic [2:0] c_OP_LSR  = 3'b011;
    localparam logic [2:0] c_OP_ASR  = 3'b100;
    localparam logic [2:0] c_OP_ROL  = 3'b101;
    localparam logic [2:0] c_OP_ROR  = 3'b110;

    logic [WIDTH-1:0] r_q;
    logic             r_done;

    // Single-position step; non-shift opcodes pass the value through.
    function automatic logic [WIDTH-1:0] f_step(input logic [2:0] op,
                                                input logic [WIDTH-1:0] v);
        case (op)
            c_OP_LSL: f_step = {v[WIDTH-2:0], 1'b0};
            c_OP_LSR: f_step = {1'b0, v[WIDTH-1:1]};
            c_OP_ASR: f_step = {v[WIDTH-1], v[WIDTH-1:1]};
            c_OP_ROL: f_step = {v[WIDTH-2:0], v[WIDTH-1]};
            c_OP_ROR: f_step = {v[0], v[WIDTH-1:1]};
            default:  f_step = v;
        endcase
    endfunction

`ifdef SHIFTER_BARREL_EN
    logic [WIDTH-1:0] w_barrel;

    // Cascade of single steps keeps n>=WIDTH results identical to iterative mode.
    always_comb begin
        w_barrel = r_q;
        for (int i = 0; i < (1 << AMT_W) - 1; i++) begin
            if (i < int'(bus.amt)) begin
                w_barrel = f_step(bus.op, w_barrel);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q    <= '0;
            r_done <= 1'b0;
        end else if (bus.clr) begin
            r_q    <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.start) begin
                r_done <= 1'b1;
                if (bus.op == c_OP_LOAD) begin
                    r_q <= bus.d_in;
                end else begin
                    r_q <= w_barrel;
                end
            end
        end
    end

    assign bus.busy = 1'b0;
`else
    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [AMT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic             w_is_shift;

    assign w_is_shift = (bus.op >= c_OP_LSL) && (bus.op <= c_OP_ROR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q     <= '0;
            r_done  <= 1'b0;
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
        end else if (bus.clr) begin
            r_q     <= '0;
            r_done  <= 1'b0;
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (bus.start) begin
                        r_op <= bus.op;
                        if (bus.op == c_OP_LOAD) begin
                            r_q    <= bus.d_in;
                            r_done <= 1'b1;
                        end else if (w_is_shift && (bus.amt != '0)) begin
                            r_state <= c_S_SHIFT;
                            r_cnt   <= bus.amt;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_q   <= f_step(r_op, r_q);
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == {{(AMT_W-1){1'b0}}, 1'b1}) begin
                        r_state <= c_S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.busy = (r_state == c_S_SHIFT);
`endif

    assign bus.q    = r_q;
    assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb__shifter_reg_p.sv
`default_nettype none
// ============================================================================
// Module      : tb__shifter_reg_p
// Description : Scoreboard bench for _shifter_reg_p (WIDTH=8, AMT_W=3).
// Revision    : 1.0  initial release
// ============================================================================
module tb__shifter_reg_p;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_LSL  = 3'b010;
    localparam logic [2:0] OP_LSR  = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [2:0] OP_NOP7 = 3'b111;

    logic clk;
    logic reset;
    int   cyc;
    int   n_vec;
    int   n_miss;

    typedef struct {
        logic [7:0] q;
        int         due;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_q;

    _shifter_reg_p_if #(.WIDTH(8), .AMT_W(3)) bus ();

    _shifter_reg_p #(.WIDTH(8), .AMT_W(3)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent reference: whole-amount shifts rather than repeated steps.
    function automatic logic [7:0] model(input logic [2:0] op, input logic [2:0] amt,
                                         input logic [7:0] d, input logic [7:0] cur);
        case (op)
            OP_LOAD: model = d;
            OP_LSL:  model = cur << amt;
            OP_LSR:  model = cur >> amt;
            OP_ASR:  model = $signed(cur) >>> amt;
            OP_ROL:  model = (cur << amt) | (cur >> (8 - amt));
            OP_ROR:  model = (cur >> amt) | (cur << (8 - amt));
            default: model = cur;
        endcase
    endfunction

    function automatic int lat(input logic [2:0] op, input logic [2:0] amt);
`ifdef SHIFTER_BARREL_EN
        lat = 0;
`else
        lat = ((op >= OP_LSL) && (op <= OP_ROR)) ? int'(amt) : 0;
`endif
    endfunction

    // Completion monitor: every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (sb.size() == 0) begin
                check_val("spurious_done", 32'(bus.done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val({e.tag, "_q"}, 32'(bus.q), 32'(e.q));
                check_val({e.tag, "_lat"}, 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [2:0] amt,
                         input logic [7:0] d, output int e0);
        bus.op    = op;
        bus.amt   = amt;
        bus.d_in  = d;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e0 = cyc;
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [2:0] amt,
                       input logic [7:0] d, input logic [7:0] exp);
        int e0;
        int l;
        l = lat(op, amt);
        issue(op, amt, d, e0);
        sb.push_back('{exp, e0 + l, tag});
        for (int k = 0; k <= l; k++) begin
            @(negedge clk);
            check_val({tag, "_busy"}, 32'(bus.busy), 32'(k < l));
        end
        #1;
        check_val({tag, "_done_seen"}, 32'(sb.size()), 32'd0);
        sb.delete();
        m_q = exp;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        #1;
        check_val(tag, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        int e0;
        logic [2:0] op;
        logic [2:0] amt;
        logic [7:0] d;
        logic [7:0] exp;

        n_vec     = 0;
        n_miss    = 0;
        cyc       = 0;
        m_q       = 8'h00;
        reset     = 1'b1;
        bus.clr   = 1'b0;
        bus.start = 1'b0;
        bus.op    = OP_NOP;
        bus.amt   = 3'd0;
        bus.d_in  = 8'h00;

        repeat (2) @(negedge clk);
        check_val("rst_q", 32'(bus.q), 32'h00);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Reset mid-shift aborts without a completion pulse.
        run("ld5a", OP_LOAD, 3'd0, 8'h5A, 8'h5A);
`ifndef SHIFTER_BARREL_EN
        issue(OP_LSL, 3'd5, 8'h00, e0);
        repeat (2) @(negedge clk);
        check_val("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_val("midrst_q", 32'(bus.q), 32'h00);
        check_val("midrst_busy", 32'(bus.busy), 32'd0);
        check_val("midrst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check_val("post_rst_busy", 32'(bus.busy), 32'd0);
        m_q = 8'h00;
`endif

        run("ldb4", OP_LOAD, 3'd0, 8'hB4, 8'hB4);
        run("lsl3", OP_LSL, 3'd3, 8'h00, 8'hA0);
        run("ld96", OP_LOAD, 3'd0, 8'h96, 8'h96);
        run("asr2", OP_ASR, 3'd2, 8'h00, 8'hE5);
        run("ror7", OP_ROR, 3'd7, 8'h00, 8'hCB);
        run("rol0", OP_ROL, 3'd0, 8'h00, 8'hCB);
        run("nop", OP_NOP, 3'd4, 8'h11, 8'hCB);
        run("nop7", OP_NOP7, 3'd5, 8'h22, 8'hCB);

        // Start during busy is ignored; op/amt changes after acceptance are ignored.
        run("ld81", OP_LOAD, 3'd0, 8'h81, 8'h81);
        issue(OP_LSR, 3'd6, 8'h00, e0);
        sb.push_back('{8'h02, e0 + lat(OP_LSR, 3'd6), "lsr6"});
`ifndef SHIFTER_BARREL_EN
        @(negedge clk);
        bus.op    = OP_LOAD;
        bus.amt   = 3'd1;
        bus.d_in  = 8'hFF;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check_val("ign_busy", 32'(bus.busy), 32'd1);
`endif
        wait_done("lsr6_done_seen");
        m_q = 8'h02;

        // Back-to-back: each command issued in the prior completion cycle.
        run("lsl2_b2b", OP_LSL, 3'd2, 8'h00, 8'h08);
        run("rol3_b2b", OP_ROL, 3'd3, 8'h00, 8'h40);
        run("ror1_b2b", OP_ROR, 3'd1, 8'h00, 8'h20);

        // Mixed patterns against the reference model.
        for (int i = 0; i < 24; i++) begin
            op  = 3'($urandom_range(0, 7));
            amt = 3'($urandom_range(0, 7));
            d   = 8'($urandom);
            exp = model(op, amt, d, m_q);
            run($sformatf("rnd%0d", i), op, amt, d, exp);
        end

        // clr coincident with start aborts everything and ignores the start.
        run("ldc3", OP_LOAD, 3'd0, 8'hC3, 8'hC3);
        issue(OP_ROR, 3'd6, 8'h00, e0);
`ifdef SHIFTER_BARREL_EN
        sb.push_back('{8'h0F, e0, "ror6"});
        wait_done("ror6_done_seen");
`else
        repeat (2) @(negedge clk);
        check_val("preclr_busy", 32'(bus.busy), 32'd1);
`endif
        bus.clr   = 1'b1;
        bus.start = 1'b1;
        bus.op    = OP_LOAD;
        bus.d_in  = 8'hAA;
        @(posedge clk);
        #1;
        bus.clr   = 1'b0;
        bus.start = 1'b0;
        check_val("clr_q", 32'(bus.q), 32'h00);
        check_val("clr_busy", 32'(bus.busy), 32'd0);
        check_val("clr_done", 32'(bus.done), 32'd0);
        repeat (8) @(negedge clk);
        check_val("postclr_q", 32'(bus.q), 32'h00);
        m_q = 8'h00;
        run("ld_after_clr", OP_LOAD, 3'd0, 8'h3C, 8'h3C);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
